// File: rtl/register_file_nw_multi_port_read_pkg.sv
// Shared types and helpers for the multi-writer, multi-reader flop register file.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package scm_rf_pkg;

  typedef enum logic {RF_INIT, RF_RUN} rf_state_e;

  // Widest row the mask helper supports (64 bytes = 512 bits).
  localparam int unsigned RF_MAX_BYTES = 64;

  // Expand a byte-enable vector to a bit mask; callers zero-extend the enables
  // and truncate the mask to their own row width.
  function automatic logic [RF_MAX_BYTES*8-1:0] be_to_mask(input logic [RF_MAX_BYTES-1:0] be);
    logic [RF_MAX_BYTES*8-1:0] m;
    for (int b = 0; b < RF_MAX_BYTES; b++) begin
      m[b*8 +: 8] = {8{be[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/register_file_nw_multi_port_read_write_merge.sv
// Merges all write ports targeting one row into that row's next value and flags losing ports.
// Latency: purely combinational.
// Backpressure: none; a losing port is only reported, never stalled.
module rf_write_merge
  import scm_rf_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int N_WRITE    = 2
) (
  input  logic [ADDR_WIDTH-1:0]                 row,
  input  logic [DATA_WIDTH-1:0]                 cur_row,
  input  logic [N_WRITE-1:0]                    en,
  input  logic [N_WRITE-1:0][ADDR_WIDTH-1:0]    addr,
  input  logic [N_WRITE-1:0][DATA_WIDTH/8-1:0]  be,
  input  logic [N_WRITE-1:0][DATA_WIDTH-1:0]    data,
  output logic [DATA_WIDTH-1:0]                 next_row,
  output logic [N_WRITE-1:0]                    loser
);

  localparam int NB = DATA_WIDTH / 8;

  logic [NB-1:0]         taken;
  logic [NB-1:0]         grant;
  logic [DATA_WIDTH-1:0] mask;

  // Walk ports from highest index down: a byte already claimed by a higher port
  // is not overwritten, and the lower port that also wanted it is marked as a loser.
  always_comb begin
    next_row = cur_row;
    loser    = '0;
    taken    = '0;
    grant    = '0;
    mask     = '0;
    for (int w = N_WRITE - 1; w >= 0; w--) begin
      if (en[w] && (addr[w] == row)) begin
        grant    = be[w] & ~taken;
        mask     = DATA_WIDTH'(be_to_mask(RF_MAX_BYTES'(grant)));
        next_row = (next_row & ~mask) | (data[w] & mask);
        loser[w] = |(be[w] & taken);
        taken    = taken | be[w];
      end
    end
  end

endmodule

// File: rtl/register_file_nw_multi_port_read.sv
// Flop register file: N_WRITE byte-enabled writers, N_READ registered readers, INIT sweep after reset.
// Latency: reads 1 cycle after ReadEnable; writes visible to the next cycle's reads (same cycle if BYPASS).
// Backpressure: none; all ports are ignored until Ready, and colliding writes resolve by port index.
module register_file_nw_multi_port_read
  import scm_rf_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 5,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    N_READ     = 2,
  parameter int                    N_WRITE    = 2,
  parameter int                    N_ROWS     = 2**ADDR_WIDTH,
  parameter int                    BYPASS     = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  output logic                                  Ready,
  input  logic [N_READ-1:0]                     ReadEnable,
  input  logic [N_READ-1:0][ADDR_WIDTH-1:0]     ReadAddr,
  output logic [N_READ-1:0][DATA_WIDTH-1:0]     ReadData,
  input  logic [N_WRITE-1:0]                    WriteEnable,
  input  logic [N_WRITE-1:0][ADDR_WIDTH-1:0]    WriteAddr,
  input  logic [N_WRITE-1:0][DATA_WIDTH/8-1:0]  WriteBE,
  input  logic [N_WRITE-1:0][DATA_WIDTH-1:0]    WriteData,
  output logic [N_WRITE-1:0]                    WriteConflict
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(N_ROWS - 1);
  localparam logic [ADDR_WIDTH:0]   ROWS_LIM = (ADDR_WIDTH + 1)'(N_ROWS);

  rf_state_e             state;
  rf_state_e             state_next;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  last_row;

  logic [DATA_WIDTH-1:0] mem       [N_ROWS];
  logic [DATA_WIDTH-1:0] row_next  [N_ROWS];
  logic [N_WRITE-1:0]    row_loser [N_ROWS];
  logic [N_WRITE-1:0]    loser_any;
  logic [DATA_WIDTH-1:0] rd_val    [N_READ];

  assign last_row = (cnt == LAST_ROW);
  assign Ready    = (state == RF_RUN);

  // One merge per row; out-of-range write addresses match no row and vanish.
  for (genvar i = 0; i < N_ROWS; i++) begin : gen_row
    rf_write_merge #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .N_WRITE    (N_WRITE)
    ) u_merge (
      .row      (ADDR_WIDTH'(i)),
      .cur_row  (mem[i]),
      .en       (WriteEnable),
      .addr     (WriteAddr),
      .be       (WriteBE),
      .data     (WriteData),
      .next_row (row_next[i]),
      .loser    (row_loser[i])
    );
  end

  // State register; reset always restarts the sweep.
  always_ff @(posedge clk) begin
    if (rst) state <= RF_INIT;
    else     state <= state_next;
  end

  // Leave INIT once the last row has been cleared.
  always_comb begin
    state_next = state;
    if ((state == RF_INIT) && last_row) state_next = RF_RUN;
  end

  // INIT sweep row counter.
  always_ff @(posedge clk) begin
    if (rst)                   cnt <= '0;
    else if (state == RF_INIT) cnt <= cnt + 1'b1;
  end

  // Storage: INIT clears one row per cycle, RUN takes the merged rows. No write lands on a reset edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N_ROWS; i++) begin
        if (state == RF_INIT) begin
          if (cnt == ADDR_WIDTH'(i)) mem[i] <= INIT_VALUE;
        end else begin
          mem[i] <= row_next[i];
        end
      end
    end
  end

  // A port lost if it lost a byte on any row (it can only address one row anyway).
  always_comb begin
    loser_any = '0;
    for (int i = 0; i < N_ROWS; i++) loser_any = loser_any | row_loser[i];
  end

  // Read mux: out-of-range rows read as zero; bypass picks the post-merge row.
  always_comb begin
    for (int r = 0; r < N_READ; r++) begin
      rd_val[r] = '0;
      if ({1'b0, ReadAddr[r]} < ROWS_LIM) begin
        rd_val[r] = (BYPASS != 0) ? row_next[ReadAddr[r]] : mem[ReadAddr[r]];
      end
    end
  end

  // Output registers: read data holds when not enabled, conflict pulses for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ReadData      <= '0;
      WriteConflict <= '0;
    end else if (state == RF_RUN) begin
      WriteConflict <= loser_any;
      for (int r = 0; r < N_READ; r++) begin
        if (ReadEnable[r]) ReadData[r] <= rd_val[r];
      end
    end else begin
      WriteConflict <= '0;
    end
  end

endmodule

// File: tb/tb_register_file_nw_multi_port_read.sv
// Bench for the multi-port register file: three instances (plain, bypass, 24 rows) on shared stimulus.
// Latency: expectations queued per cycle and checked on the following falling edge.
// Backpressure: not applicable.
module tb_register_file_nw_multi_port_read;

  localparam int          AW = 5;
  localparam int          DW = 32;
  localparam int          NR = 2;
  localparam int          NW = 2;
  localparam logic [31:0] IV = 32'h5A5A_0F0F;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [NR-1:0]          ReadEnable;
  logic [NR-1:0][AW-1:0]  ReadAddr;
  logic [NW-1:0]          WriteEnable;
  logic [NW-1:0][AW-1:0]  WriteAddr;
  logic [NW-1:0][3:0]     WriteBE;
  logic [NW-1:0][DW-1:0]  WriteData;

  logic                   ready_a, ready_b, ready_c;
  logic [NR-1:0][DW-1:0]  rd_a, rd_b, rd_c;
  logic [NW-1:0]          wc_a, wc_b, wc_c;

  always #5 clk = ~clk;

  register_file_nw_multi_port_read #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_READ(NR), .N_WRITE(NW),
    .N_ROWS(32), .BYPASS(0), .INIT_VALUE(IV)
  ) dut (
    .clk(clk), .rst(rst), .Ready(ready_a),
    .ReadEnable(ReadEnable), .ReadAddr(ReadAddr), .ReadData(rd_a),
    .WriteEnable(WriteEnable), .WriteAddr(WriteAddr), .WriteBE(WriteBE),
    .WriteData(WriteData), .WriteConflict(wc_a)
  );

  register_file_nw_multi_port_read #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_READ(NR), .N_WRITE(NW),
    .N_ROWS(32), .BYPASS(1), .INIT_VALUE(IV)
  ) dut_byp (
    .clk(clk), .rst(rst), .Ready(ready_b),
    .ReadEnable(ReadEnable), .ReadAddr(ReadAddr), .ReadData(rd_b),
    .WriteEnable(WriteEnable), .WriteAddr(WriteAddr), .WriteBE(WriteBE),
    .WriteData(WriteData), .WriteConflict(wc_b)
  );

  register_file_nw_multi_port_read #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_READ(NR), .N_WRITE(NW),
    .N_ROWS(24), .BYPASS(0), .INIT_VALUE(IV)
  ) dut_24 (
    .clk(clk), .rst(rst), .Ready(ready_c),
    .ReadEnable(ReadEnable), .ReadAddr(ReadAddr), .ReadData(rd_c),
    .WriteEnable(WriteEnable), .WriteAddr(WriteAddr), .WriteBE(WriteBE),
    .WriteData(WriteData), .WriteConflict(wc_c)
  );

  typedef struct {
    string       tag;
    int          kind;   // 0 read data, 1 conflict vector, 2 ready
    int          inst;
    int          port;
    logic [31:0] exp;
  } exp_t;

  exp_t        sbq[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] mdl     [3][32];
  logic [31:0] last_rd [3][2];
  int          rows_of [3] = '{32, 32, 24};
  int          byp_of  [3] = '{0, 1, 0};
  int          since_rst = 0;

  function automatic logic [31:0] observe(int kind, int inst, int port);
    logic [31:0] v;
    v = '0;
    case (kind)
      0: case (inst)
           0: v = rd_a[port];
           1: v = rd_b[port];
           default: v = rd_c[port];
         endcase
      1: case (inst)
           0: v = {30'b0, wc_a};
           1: v = {30'b0, wc_b};
           default: v = {30'b0, wc_c};
         endcase
      default: case (inst)
           0: v = {31'b0, ready_a};
           1: v = {31'b0, ready_b};
           default: v = {31'b0, ready_c};
         endcase
    endcase
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Predict every output for the coming edge from the current inputs, clock once, then compare.
  task automatic run_cycle(input string tag);
    logic [31:0] pre  [32];
    logic [31:0] post [32];
    logic [1:0]  lost;
    logic        running;
    logic        rdy;
    exp_t        e;
    for (int i = 0; i < 3; i++) begin
      running = !rst && (since_rst >= rows_of[i]);
      rdy     = !rst && (since_rst + 1 >= rows_of[i]);
      lost    = '0;
      for (int k = 0; k < 32; k++) begin
        pre[k]  = mdl[i][k];
        post[k] = mdl[i][k];
      end
      if (running) begin
        for (int w = 0; w < NW; w++) begin
          if (WriteEnable[w] && (int'(WriteAddr[w]) < rows_of[i])) begin
            for (int b = 0; b < 4; b++) begin
              if (WriteBE[w][b]) post[WriteAddr[w]][b*8 +: 8] = WriteData[w][b*8 +: 8];
            end
          end
        end
        for (int w = 0; w < NW; w++) begin
          for (int h = w + 1; h < NW; h++) begin
            if (WriteEnable[w] && WriteEnable[h] && (WriteAddr[w] == WriteAddr[h]) &&
                (int'(WriteAddr[w]) < rows_of[i]) && ((WriteBE[w] & WriteBE[h]) != 4'b0))
              lost[w] = 1'b1;
          end
        end
        for (int r = 0; r < NR; r++) begin
          if (ReadEnable[r]) begin
            if (int'(ReadAddr[r]) >= rows_of[i]) last_rd[i][r] = '0;
            else last_rd[i][r] = (byp_of[i] != 0) ? post[ReadAddr[r]] : pre[ReadAddr[r]];
          end
        end
        for (int k = 0; k < 32; k++) mdl[i][k] = post[k];
      end else if (rst) begin
        for (int r = 0; r < NR; r++) last_rd[i][r] = '0;
        for (int k = 0; k < 32; k++) mdl[i][k] = IV;
      end
      for (int r = 0; r < NR; r++) begin
        e = '{tag: $sformatf("%s/i%0d/rd%0d", tag, i, r), kind: 0, inst: i, port: r, exp: last_rd[i][r]};
        sbq.push_back(e);
      end
      e = '{tag: $sformatf("%s/i%0d/conflict", tag, i), kind: 1, inst: i, port: 0, exp: {30'b0, lost}};
      sbq.push_back(e);
      e = '{tag: $sformatf("%s/i%0d/ready", tag, i), kind: 2, inst: i, port: 0, exp: {31'b0, rdy}};
      sbq.push_back(e);
    end
    since_rst = rst ? 0 : since_rst + 1;
    @(posedge clk);
    @(negedge clk);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      check(e.tag, observe(e.kind, e.inst, e.port), e.exp);
    end
  endtask

  task automatic random_traffic();
    ReadEnable = 2'($urandom_range(0, 3));
    for (int r = 0; r < NR; r++) ReadAddr[r] = 5'($urandom_range(0, 31));
    WriteEnable = 2'($urandom_range(0, 3));
    for (int w = 0; w < NW; w++) begin
      WriteAddr[w] = 5'($urandom_range(0, 31));
      WriteBE[w]   = 4'($urandom_range(0, 15));
      WriteData[w] = $urandom;
    end
  endtask

  task automatic sweep(input string tag);
    WriteEnable = '0;
    for (int k = 0; k < 32; k++) begin
      ReadEnable  = 2'b11;
      ReadAddr[0] = 5'(k);
      ReadAddr[1] = 5'(31 - k);
      run_cycle(tag);
    end
    ReadEnable = '0;
  endtask

  initial begin
    ReadEnable  = '0;
    ReadAddr    = '0;
    WriteEnable = '0;
    WriteAddr   = '0;
    WriteBE     = '0;
    WriteData   = '0;
    rst         = 1'b1;
    @(negedge clk);

    // Reset state, then the INIT sweep with Ready tracked every cycle.
    run_cycle("reset");
    run_cycle("reset");
    rst = 1'b0;
    for (int k = 0; k < 34; k++) run_cycle("init");
    sweep("init_sweep");
    run_cycle("hold");

    // Full-word write then dual-port read of the same row.
    WriteEnable = 2'b01; WriteAddr[0] = 5'd3; WriteBE[0] = 4'hF; WriteData[0] = 32'hAABBCCDD;
    run_cycle("t2_wr");
    WriteEnable = '0; ReadEnable = 2'b11; ReadAddr[0] = 5'd3; ReadAddr[1] = 5'd3;
    run_cycle("t2_rd");
    check("t2_port0", rd_a[0], 32'hAABBCCDD);
    check("t2_port1", rd_a[1], 32'hAABBCCDD);
    ReadEnable = '0;
    run_cycle("t2_hold");

    // Two writers on one row with overlapping bytes.
    WriteEnable = 2'b11;
    WriteAddr[0] = 5'd7; WriteBE[0] = 4'hF; WriteData[0] = 32'h11111111;
    WriteAddr[1] = 5'd7; WriteBE[1] = 4'h3; WriteData[1] = 32'h22222222;
    run_cycle("t3_wr");
    check("t3_conflict", {30'b0, wc_a}, 32'h1);
    WriteEnable = '0; ReadEnable = 2'b01; ReadAddr[0] = 5'd7;
    run_cycle("t3_rd");
    check("t3_row7", rd_a[0], 32'h11112222);
    check("t3_conflict_gone", {30'b0, wc_a}, 32'h0);

    // Same-cycle read and write of one row, with and without bypass.
    ReadEnable = '0; WriteEnable = 2'b01; WriteAddr[0] = 5'd5; WriteBE[0] = 4'hF; WriteData[0] = 32'h0;
    run_cycle("t4_clr");
    WriteData[0] = 32'hDEADBEEF; ReadEnable = 2'b11; ReadAddr[0] = 5'd5; ReadAddr[1] = 5'd5;
    run_cycle("t4_rw");
    check("t4_no_bypass", rd_a[0], 32'h0);
    check("t4_bypass", rd_b[0], 32'hDEADBEEF);
    WriteEnable = '0;
    run_cycle("t4_after");

    // Enable with no byte enables, and a bypassed collision.
    WriteEnable = 2'b11;
    WriteAddr[0] = 5'd9; WriteBE[0] = 4'hC; WriteData[0] = 32'hA1A2A3A4;
    WriteAddr[1] = 5'd9; WriteBE[1] = 4'h6; WriteData[1] = 32'hB1B2B3B4;
    ReadEnable = 2'b01; ReadAddr[0] = 5'd9;
    run_cycle("merge_byp");
    WriteBE[0] = 4'h0; WriteBE[1] = 4'h0;
    run_cycle("be_zero");

    // Addresses beyond the implemented rows of the 24-row instance.
    ReadEnable = '0; WriteEnable = 2'b10; WriteAddr[1] = 5'd30; WriteBE[1] = 4'hF; WriteData[1] = 32'hCAFEF00D;
    run_cycle("t6_wr");
    WriteEnable = '0; ReadEnable = 2'b01; ReadAddr[0] = 5'd30;
    run_cycle("t6_rd");
    check("t6_row30_small", rd_c[0], 32'h0);
    WriteEnable = 2'b11; WriteAddr[0] = 5'd30; WriteBE[0] = 4'hF; WriteBE[1] = 4'hF;
    run_cycle("t6_conf");
    check("t6_no_conflict_small", {30'b0, wc_c}, 32'h0);
    WriteEnable = '0; ReadEnable = '0;
    sweep("t6_sweep");

    // Random mixed traffic.
    for (int k = 0; k < 60; k++) begin
      random_traffic();
      run_cycle("rand");
    end

    // Reset pulse mid-traffic; traffic during INIT must be ignored.
    random_traffic();
    rst = 1'b1;
    run_cycle("t5_rst");
    check("t5_ready_drop", {31'b0, ready_a}, 32'h0);
    rst = 1'b0;
    for (int k = 0; k < 34; k++) begin
      random_traffic();
      run_cycle("t5_init");
    end
    sweep("t5_sweep");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
